// File: rtl/capture_sequencer.sv
// Acquisition controller for a circular sample buffer: prefill, hysteresis trigger, auto timeout,
// post-trigger fill and a ready/ack frame handoff. Optional decimation input via CAPTURE_DECIM_EN.
module capture_sequencer #(
  parameter int DEPTH   = 800,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 12,
  parameter int PRETRIG = 200,
  parameter int TIMEOUT = 2000,
  parameter int HYST    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sampleValid,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] triggerLevel,
  input  logic              triggerSlope,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic              frameAck,
`ifdef CAPTURE_DECIM_EN
  input  logic [3:0]        decim,
`endif
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              frameReady,
  output logic [ADDR_W-1:0] frameStart,
  output logic              triggered,
  output logic [2:0]        state
);

  localparam int CNT_MAX  = (TIMEOUT > DEPTH) ? TIMEOUT : DEPTH;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int POST_LEN = DEPTH - PRETRIG;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_LEN - 1);
  localparam logic [CNT_W-1:0]  TMO_LIM   = CNT_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W:0]   HYST_X    = (DATA_W + 1)'(HYST);

  localparam logic [1:0] M_NORM   = 2'd1;
  localparam logic [1:0] M_AUTO   = 2'd2;
  localparam logic [1:0] M_SINGLE = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            cur_r, nxt_s;
  logic [1:0]        mode_r, mode_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              flag_r, flag_s;
  logic              trig_r, trig_s;
  logic [ADDR_W-1:0] start_r, start_s;
  logic [ADDR_W-1:0] ptr_r, ptr_inc_s;
  logic              wr_en_r, ready_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [DATA_W:0]   lo_thr_s, hi_thr_s;
  logic              beyond_s, fire_s, capturing_s, accept_s;

  // Oldest frame address, trigger address minus the pretrigger depth, kept non-negative
  function automatic logic [ADDR_W-1:0] frame_start(input logic [ADDR_W-1:0] a);
    if (a >= ADDR_W'(PRETRIG)) begin
      frame_start = a - ADDR_W'(PRETRIG);
    end else begin
      frame_start = a + ADDR_W'(DEPTH - PRETRIG);
    end
  endfunction

  assign capturing_s = (cur_r == PREFILL) || (cur_r == ARMED) || (cur_r == POST);
  assign ptr_inc_s   = (ptr_r == ADDR_LAST) ? {ADDR_W{1'b0}} : ptr_r + ADDR_ONE;

`ifdef CAPTURE_DECIM_EN
  logic [3:0] dcnt_r;

  assign accept_s = sampleValid && capturing_s && (dcnt_r >= decim);

  // Decimation phase; held at zero outside capture so every frame starts aligned
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dcnt_r <= 4'd0;
    end else if (!capturing_s) begin
      dcnt_r <= 4'd0;
    end else if (sampleValid) begin
      dcnt_r <= (dcnt_r >= decim) ? 4'd0 : dcnt_r + 4'd1;
    end else begin
      dcnt_r <= dcnt_r;
    end
  end
`else
  assign accept_s = sampleValid && capturing_s;
`endif

  // Thresholds carry one extra bit so saturation falls out of the compare itself
  always_comb begin
    lo_thr_s = {1'b0, triggerLevel} - HYST_X;
    hi_thr_s = {1'b0, triggerLevel} + HYST_X;
    if (triggerSlope) begin
      beyond_s = ({1'b0, data} > hi_thr_s);
      fire_s   = flag_r && (data <= triggerLevel);
    end else begin
      beyond_s = !lo_thr_s[DATA_W] && ({1'b0, data} < lo_thr_s);
      fire_s   = flag_r && (data >= triggerLevel);
    end
  end

  // Next state, shared phase counter, hysteresis flag and trigger capture
  always_comb begin
    nxt_s   = cur_r;
    mode_s  = mode_r;
    cnt_s   = cnt_r;
    flag_s  = flag_r;
    trig_s  = trig_r;
    start_s = start_r;
    case (cur_r)
      IDLE: begin
        if ((mode == M_NORM) || (mode == M_AUTO) || ((mode == M_SINGLE) && arm)) begin
          nxt_s  = PREFILL;
          mode_s = mode;
          cnt_s  = CNT_ZERO;
        end else begin
          nxt_s = IDLE;
        end
      end
      PREFILL: begin
        if (accept_s && (cnt_r == PRE_LAST)) begin
          nxt_s  = ARMED;
          cnt_s  = CNT_ZERO;
          flag_s = 1'b0;
        end else if (accept_s) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          nxt_s = PREFILL;
        end
      end
      ARMED: begin
        if (accept_s && (fire_s || ((mode_r == M_AUTO) && (cnt_r == TMO_LIM)))) begin
          trig_s  = fire_s;
          start_s = frame_start(ptr_r);
          cnt_s   = CNT_ONE;
          if (POST_LEN == 1) begin
            nxt_s = DONE;
          end else begin
            nxt_s = POST;
          end
        end else if (accept_s) begin
          flag_s = flag_r | beyond_s;
          if (cnt_r != TMO_LIM) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
        end else begin
          nxt_s = ARMED;
        end
      end
      POST: begin
        if (accept_s && (cnt_r == POST_LAST)) begin
          nxt_s = DONE;
          cnt_s = CNT_ZERO;
        end else if (accept_s) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          nxt_s = POST;
        end
      end
      DONE: begin
        if (frameAck && ((mode_r == M_NORM) || (mode_r == M_AUTO)) && (mode != 2'd0)) begin
          nxt_s  = PREFILL;
          mode_s = mode;
          cnt_s  = CNT_ZERO;
        end else if (frameAck) begin
          nxt_s = IDLE;
        end else begin
          nxt_s = DONE;
        end
      end
      default: begin
        nxt_s = IDLE;
        cnt_s = CNT_ZERO;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_r <= IDLE;
    end else begin
      cur_r <= nxt_s;
    end
  end

  // Datapath and registered outputs; a write lands one cycle after its strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_r    <= 2'd0;
      cnt_r     <= CNT_ZERO;
      flag_r    <= 1'b0;
      trig_r    <= 1'b0;
      start_r   <= {ADDR_W{1'b0}};
      ptr_r     <= {ADDR_W{1'b0}};
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
      ready_r   <= 1'b0;
    end else begin
      mode_r  <= mode_s;
      cnt_r   <= cnt_s;
      flag_r  <= flag_s;
      trig_r  <= trig_s;
      start_r <= start_s;
      wr_en_r <= accept_s;
      ready_r <= (nxt_s == DONE);
      if (accept_s) begin
        ptr_r     <= ptr_inc_s;
        wr_addr_r <= ptr_r;
        wr_data_r <= data;
      end
    end
  end

  assign wrEn       = wr_en_r;
  assign wrAddr     = wr_addr_r;
  assign wrData     = wr_data_r;
  assign frameReady = ready_r;
  assign frameStart = start_r;
  assign triggered  = trig_r;
  assign state      = cur_r;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed self-checking bench for capture_sequencer (default build, no decimation port).
module tb_capture_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sampleValid = 1'b0;
  logic [11:0] data = 12'd0;
  logic [11:0] triggerLevel = 12'd2048;
  logic        triggerSlope = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        arm = 1'b0;
  logic        frameAck = 1'b0;
  logic        wrEn;
  logic [9:0]  wrAddr;
  logic [11:0] wrData;
  logic        frameReady;
  logic [9:0]  frameStart;
  logic        triggered;
  logic [2:0]  state;

  int tb_checks = 0;
  int tb_fails = 0;
  int wr_count = 0;
  int wrap_count = 0;
  logic [9:0]  last_addr = 10'd0;
  logic [11:0] mem [0:799];

  capture_sequencer dut (
    .clock(clock), .reset(reset), .sampleValid(sampleValid), .data(data),
    .triggerLevel(triggerLevel), .triggerSlope(triggerSlope), .mode(mode),
    .arm(arm), .frameAck(frameAck), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .frameReady(frameReady), .frameStart(frameStart), .triggered(triggered), .state(state)
  );

  always #5 clock = ~clock;

  // Buffer image and write bookkeeping, sampled away from the active edge
  always @(negedge clock) begin
    if (wrEn) begin
      if (wr_count > 0 && last_addr == 10'd799 && wrAddr == 10'd0) wrap_count++;
      mem[int'(wrAddr)] = wrData;
      last_addr = wrAddr;
      wr_count++;
    end
  end

  task automatic send(input logic [11:0] d);
    @(negedge clock);
    data = d;
    sampleValid = 1'b1;
    @(negedge clock);
    sampleValid = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset;
    @(negedge clock);
    mode = 2'd0; sampleValid = 1'b0; frameAck = 1'b0; arm = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; mode = 2'd1; sampleValid = 1'b1; data = 12'hABC;
    repeat (3) @(negedge clock);
    tb_checks++;
    if ({wrEn, wrAddr, wrData, frameReady, frameStart, triggered, state} !== 39'd0) begin
      tb_fails++;
      $display("FAIL reset_outputs: wrEn=%0b wrAddr=%0d wrData=%0d ready=%0b start=%0d trig=%0b state=%0d expected all 0",
               wrEn, wrAddr, wrData, frameReady, frameStart, triggered, state);
    end
    sampleValid = 1'b0; mode = 2'd0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_normal_ramp;
    int base;
    int n;
    do_reset;
    triggerLevel = 12'd2048; triggerSlope = 1'b0; mode = 2'd1;
    base = wr_count; n = 0;
    repeat (200) begin send(12'(n * 8)); n++; end
    tb_checks++;
    if (state !== 3'd2 || wr_count - base != 200) begin
      tb_fails++;
      $display("FAIL ramp_prefill: state=%0d writes=%0d expected state 2 writes 200", state, wr_count - base);
    end
    while (!frameReady && n < 1200) begin send(12'(n * 8)); n++; end
    tb_checks++;
    if (n != 856 || wr_count - base != 856) begin
      tb_fails++;
      $display("FAIL ramp_count: samples=%0d writes=%0d expected 856/856", n, wr_count - base);
    end
    tb_checks++;
    if (frameReady !== 1'b1 || triggered !== 1'b1 || frameStart !== 10'd56) begin
      tb_fails++;
      $display("FAIL ramp_frame: ready=%0b trig=%0b start=%0d expected 1/1/56", frameReady, triggered, frameStart);
    end
    tb_checks++;
    if (mem[256] !== 12'd2048 || mem[255] !== 12'd2040) begin
      tb_fails++;
      $display("FAIL ramp_trig_data: mem256=%0d mem255=%0d expected 2048/2040", mem[256], mem[255]);
    end
    repeat (10) send(12'd100);
    tb_checks++;
    if (wr_count - base != 856 || state !== 3'd4) begin
      tb_fails++;
      $display("FAIL ramp_frozen: writes=%0d state=%0d expected 856/4", wr_count - base, state);
    end
    @(negedge clock);
    frameAck = 1'b1; sampleValid = 1'b1; data = 12'd5;
    @(negedge clock);
    frameAck = 1'b0; sampleValid = 1'b0;
    repeat (2) @(negedge clock);
    tb_checks++;
    if (frameReady !== 1'b0 || state !== 3'd1 || wr_count - base != 856) begin
      tb_fails++;
      $display("FAIL ramp_ack: ready=%0b state=%0d writes=%0d expected 0/1/856", frameReady, state, wr_count - base);
    end
  endtask

  task automatic test_hysteresis;
    int base;
    int n;
    do_reset;
    triggerLevel = 12'd2048; triggerSlope = 1'b0; mode = 2'd1;
    base = wr_count;
    for (int k = 0; k < 500; k++) send(12'(2040 + (k * 7) % 16));
    tb_checks++;
    if (state !== 3'd2 || frameReady !== 1'b0 || wr_count - base != 500) begin
      tb_fails++;
      $display("FAIL hyst_no_trigger: state=%0d ready=%0b writes=%0d expected 2/0/500", state, frameReady, wr_count - base);
    end
    do_reset;
    mode = 2'd2;
    base = wr_count; n = 0;
    while (!frameReady && n < 3200) begin send(12'(2040 + (n * 7) % 16)); n++; end
    tb_checks++;
    if (n != 2800 || wr_count - base != 2800) begin
      tb_fails++;
      $display("FAIL auto_count: samples=%0d writes=%0d expected 2800/2800", n, wr_count - base);
    end
    tb_checks++;
    if (frameReady !== 1'b1 || triggered !== 1'b0 || frameStart !== 10'd400) begin
      tb_fails++;
      $display("FAIL auto_frame: ready=%0b trig=%0b start=%0d expected 1/0/400", frameReady, triggered, frameStart);
    end
  endtask

  task automatic test_single;
    int base;
    int n;
    do_reset;
    triggerLevel = 12'd2048; triggerSlope = 1'b0; mode = 2'd3;
    base = wr_count;
    repeat (50) send(12'd0);
    tb_checks++;
    if (state !== 3'd0 || wr_count - base != 0) begin
      tb_fails++;
      $display("FAIL single_no_arm: state=%0d writes=%0d expected 0/0", state, wr_count - base);
    end
    @(negedge clock); arm = 1'b1;
    @(negedge clock); arm = 1'b0;
    tb_checks++;
    if (state !== 3'd1) begin
      tb_fails++;
      $display("FAIL single_arm: state=%0d expected 1", state);
    end
    repeat (201) send(12'd0);
    send(12'd4095);
    n = 202;
    while (!frameReady && n < 1000) begin send(12'd0); n++; end
    tb_checks++;
    if (wr_count - base != 801 || triggered !== 1'b1 || frameStart !== 10'd1) begin
      tb_fails++;
      $display("FAIL single_frame: writes=%0d trig=%0b start=%0d expected 801/1/1", wr_count - base, triggered, frameStart);
    end
    @(negedge clock); frameAck = 1'b1;
    @(negedge clock); frameAck = 1'b0;
    repeat (20) send(12'd0);
    tb_checks++;
    if (state !== 3'd0 || frameReady !== 1'b0 || wr_count - base != 801) begin
      tb_fails++;
      $display("FAIL single_idle: state=%0d ready=%0b writes=%0d expected 0/0/801", state, frameReady, wr_count - base);
    end
  endtask

  task automatic test_wrap;
    int base;
    int wb;
    int n;
    do_reset;
    triggerLevel = 12'd2048; triggerSlope = 1'b0; mode = 2'd1;
    base = wr_count;
    repeat (700) send(12'd0);
    wb = wrap_count;
    send(12'd3000);
    n = 701;
    while (!frameReady && n < 1500) begin send(12'd0); n++; end
    tb_checks++;
    if (wr_count - base != 1300 || frameStart !== 10'd500 || mem[700] !== 12'd3000) begin
      tb_fails++;
      $display("FAIL wrap_frame: writes=%0d start=%0d mem700=%0d expected 1300/500/3000", wr_count - base, frameStart, mem[700]);
    end
    tb_checks++;
    if (wrap_count - wb != 1 || last_addr !== 10'd499 || triggered !== 1'b1) begin
      tb_fails++;
      $display("FAIL wrap_seq: wraps=%0d last=%0d trig=%0b expected 1/499/1", wrap_count - wb, last_addr, triggered);
    end
  endtask

  task automatic test_reset_mid_post;
    int base;
    do_reset;
    triggerLevel = 12'd2048; triggerSlope = 1'b0; mode = 2'd1;
    repeat (201) send(12'd0);
    send(12'd3000);
    repeat (100) send(12'd0);
    tb_checks++;
    if (state !== 3'd3) begin
      tb_fails++;
      $display("FAIL midpost_state: state=%0d expected 3", state);
    end
    @(negedge clock); data = 12'd77; sampleValid = 1'b1;
    @(posedge clock); #1;
    tb_checks++;
    if (wrEn !== 1'b1) begin
      tb_fails++;
      $display("FAIL midpost_write: wrEn=%0b expected 1", wrEn);
    end
    #1; reset = 1'b1; sampleValid = 1'b0;
    #1;
    tb_checks++;
    if ({wrEn, wrAddr, wrData, frameReady, frameStart, triggered, state} !== 39'd0) begin
      tb_fails++;
      $display("FAIL midpost_async: wrEn=%0b wrAddr=%0d wrData=%0d ready=%0b start=%0d trig=%0b state=%0d expected all 0",
               wrEn, wrAddr, wrData, frameReady, frameStart, triggered, state);
    end
    @(negedge clock); reset = 1'b0;
    base = wr_count;
    send(12'd9);
    tb_checks++;
    if (wr_count - base != 1 || last_addr !== 10'd0 || state !== 3'd1) begin
      tb_fails++;
      $display("FAIL midpost_restart: writes=%0d addr=%0d state=%0d expected 1/0/1", wr_count - base, last_addr, state);
    end
  endtask

  task automatic test_falling;
    logic [11:0] sine [0:63];
    logic        flag;
    int          ti;
    int          base;
    int          n;
    for (int k = 0; k < 64; k++) sine[k] = 12'($rtoi(2048.0 + 2047.0 * $sin(6.283185307179586 * k / 64.0)));
    flag = 1'b0; ti = -1;
    for (int i = 200; i < 1200 && ti < 0; i++) begin
      if (flag && sine[i % 64] <= 12'd1000) ti = i;
      else if (sine[i % 64] > 12'd1016) flag = 1'b1;
    end
    do_reset;
    triggerLevel = 12'd1000; triggerSlope = 1'b1; mode = 2'd1;
    base = wr_count; n = 0;
    while (!frameReady && n < 2000) begin send(sine[n % 64]); n++; end
    tb_checks++;
    if (n != ti + 600 || frameStart !== 10'((ti + 600) % 800) || triggered !== 1'b1) begin
      tb_fails++;
      $display("FAIL fall_frame: samples=%0d start=%0d trig=%0b expected %0d/%0d/1", n, frameStart, triggered, ti + 600, (ti + 600) % 800);
    end
    tb_checks++;
    if (mem[ti % 800] > 12'd1000 || mem[(ti - 1) % 800] <= 12'd1000) begin
      tb_fails++;
      $display("FAIL fall_cross: trig_sample=%0d prev=%0d expected <=1000 and >1000", mem[ti % 800], mem[(ti - 1) % 800]);
    end
    @(negedge clock); mode = 2'd0;
    repeat (5) send(12'd2000);
    @(negedge clock); frameAck = 1'b1;
    @(negedge clock); frameAck = 1'b0;
    repeat (3) @(negedge clock);
    tb_checks++;
    if (state !== 3'd0 || frameReady !== 1'b0 || wr_count - base != ti + 600) begin
      tb_fails++;
      $display("FAIL fall_to_idle: state=%0d ready=%0b writes=%0d expected 0/0/%0d", state, frameReady, wr_count - base, ti + 600);
    end
  endtask

  initial begin
    test_reset;
    test_normal_ramp;
    test_hysteresis;
    test_single;
    test_wrap;
    test_reset_mid_post;
    test_falling;
    $display("End of test - %0d assertions evaluated, %0d failures", tb_checks, tb_fails);
    $finish;
  end

endmodule
